// File: rtl/joydb9_pkg.sv
// Shared types and constants for the DB9 joystick shift-register scanner.
package joydb9_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LATCH,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_DONE,
        ST_GAP
    } state_e;

    // Bit positions inside each published pad word
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int FIRE1 = 4;
    localparam int FIRE2 = 5;
    localparam int FIRE3 = 6;
    localparam int START = 7;

    localparam int NBITS_PAD = 8;

endpackage

// File: rtl/joydb9_tick.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks, first tick CLK_DIV cycles after reset.
module joydb9_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/joydb9_scan.sv
// Scans two chained parallel-in/serial-out registers and publishes two active-high pad words per frame.
module joydb9_scan
    import joydb9_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int NBITS   = 16,
    parameter int GAP     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 JOY_DATA,
    output logic                 JOY_CLK,
    output logic                 JOY_LOAD_N,
    output logic [NBITS_PAD-1:0] joy1,
    output logic [NBITS_PAD-1:0] joy2,
    output logic                 valid,
    output logic                 busy
);

    localparam int BW = $clog2(NBITS + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_e               state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [NBITS-1:0]     sr_q, sr_d;
    logic [1:0]           sync_q;
    logic                 jclk_q, jclk_d;
    logic                 load_n_q, load_n_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [NBITS_PAD-1:0] joy1_q, joy1_d;
    logic [NBITS_PAD-1:0] joy2_q, joy2_d;
    logic                 tick;
    logic                 din;

    joydb9_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (clk),
        .rst_i  (reset),
        .tick_o (tick)
    );

    assign din = sync_q[1];

    // Pin levels are decided together with the state so they change on the advancing edge
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sr_d     = sr_q;
        jclk_d   = jclk_q;
        load_n_d = load_n_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        joy1_d   = joy1_q;
        joy2_d   = joy2_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d  = ST_LOAD;
                        load_n_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_d  = ST_LATCH;
                    load_n_d = 1'b1;
                end
                ST_LATCH: begin
                    sr_d    = {sr_q[NBITS-2:0], din};
                    bit_d   = BW'(1);
                    state_d = ST_SHIFT_HI;
                    jclk_d  = 1'b1;
                end
                ST_SHIFT_HI: begin
                    sr_d    = {sr_q[NBITS-2:0], din};
                    bit_d   = bit_q + 1'b1;
                    state_d = ST_SHIFT_LO;
                    jclk_d  = 1'b0;
                end
                ST_SHIFT_LO: begin
                    // The final low phase closes the frame; publish the whole word at once
                    if (bit_q == BW'(NBITS)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        joy1_d  = ~sr_q[NBITS-1 -: NBITS_PAD];
                        joy2_d  = ~sr_q[NBITS_PAD-1:0];
                    end else begin
                        state_d = ST_SHIFT_HI;
                        jclk_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
                ST_GAP: begin
                    if (gap_q == GW'(GAP - 1)) begin
                        if (enable) begin
                            state_d  = ST_LOAD;
                            load_n_d = 1'b0;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            gap_q    <= '0;
            sr_q     <= '1;
            sync_q   <= 2'b11;
            jclk_q   <= 1'b0;
            load_n_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            joy1_q   <= '0;
            joy2_q   <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sr_q     <= sr_d;
            sync_q   <= {sync_q[0], JOY_DATA};
            jclk_q   <= jclk_d;
            load_n_q <= load_n_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
        end
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD_N = load_n_q;
    assign joy1       = joy1_q;
    assign joy2       = joy2_q;
    assign valid      = valid_q;
    assign busy       = busy_q;

endmodule
